conv_engine: RTL and testbench

CONV_ENGINE -- requirements
Module: conv_engine

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_engine_mac_tree.sv | 36 +++
 rtl/conv_engine.sv | 202 ++++++++++++++++++++
 tb/tb_conv_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Products are 2*DW wide; 8 guard bits absorb up to 256 accumulated terms.
    function automatic int acc_w_default(input int dw);
        return 2 * dw + 8;
    endfunction

endpackage

// File: rtl/conv_engine_mac_tree.sv
// LANES signed multipliers feeding one adder tree, registered at the output.
module mac_tree #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int ACC_W = 2 * DW + 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DW-1:0]     a,
    input  logic [LANES*DW-1:0]     b,
    output logic signed [ACC_W-1:0] sum_q
);
    logic signed [2*DW-1:0]  prod [LANES];
    logic signed [ACC_W-1:0] sum_d;

    // Lane 0 occupies the MSBs of the memory word.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [2*DW-1:0] ax, bx;
        assign ax      = {{DW{a[(LANES-i)*DW-1]}}, a[(LANES-1-i)*DW +: DW]};
        assign bx      = {{DW{b[(LANES-i)*DW-1]}}, b[(LANES-1-i)*DW +: DW]};
        assign prod[i] = ax * bx;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + {{(ACC_W-2*DW){prod[i][2*DW-1]}}, prod[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

endmodule

// File: rtl/conv_engine.sv
// Fully-connected layer engine: streams ifm/weight words through a MAC tree,
// accumulates per neuron, scales/clamps the result and packs LANES results per write.
module conv_engine
    import conv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int ACC_W = acc_w_default(DW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         cfg_n_words,
    input  logic [15:0]         cfg_n_neurons,
    input  logic [4:0]          cfg_shift,
    input  logic                cfg_relu,
    output logic                busy,
    output logic                done,
    output logic                ifm_en,
    output logic [AW-1:0]       ifm_addr,
    input  logic [LANES*DW-1:0] ifm_rdata,
    output logic                w_en,
    output logic [AW-1:0]       w_addr,
    input  logic [LANES*DW-1:0] w_rdata,
    output logic                out_we,
    output logic [AW-1:0]       out_addr,
    output logic [LANES*DW-1:0] out_wdata
);
    localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

    state_e state_q, state_d;
    logic   launch_q, launch_d;
    logic [15:0] words_q, words_d, neurons_q, neurons_d;
    logic [4:0]  shift_q, shift_d;
    logic        relu_q, relu_d;
    logic [15:0] k_q, k_d, n_q, n_d;
    logic [AW-1:0] w_q, w_d;

    logic issue_vld, issue_first, issue_last, issue_fin;
    logic [3:1] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d, fin_pipe_q, fin_pipe_d;
    logic [2:1] first_pipe_q, first_pipe_d;

    logic signed [ACC_W-1:0] sum_q, acc_q, acc_d, sh;
    logic [DW-1:0]               res;
    logic                        wr;
    logic [SW-1:0]               slot_q, slot_d;
    logic [LANES-1:0][DW-1:0]    pack_q, pack_d;
    logic                        out_we_q, out_we_d, fin_wr_q, fin_wr_d;
    logic [AW-1:0]               out_addr_q, out_addr_d;

    mac_tree #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ifm_rdata),
        .b     (w_rdata),
        .sum_q (sum_q)
    );

    // Control: cfg is latched with start; the zero-size check uses the latched copy.
    always_comb begin
        state_d     = state_q;
        launch_d    = 1'b0;
        words_d     = words_q;
        neurons_d   = neurons_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        k_d         = k_q;
        n_d         = n_q;
        w_d         = w_q;
        issue_vld   = 1'b0;
        issue_first = 1'b0;
        issue_last  = 1'b0;
        issue_fin   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_q) begin
                    state_d = (words_q == '0 || neurons_q == '0) ? ST_DONE : ST_RUN;
                end else if (start) begin
                    launch_d  = 1'b1;
                    words_d   = cfg_n_words;
                    neurons_d = cfg_n_neurons;
                    shift_d   = cfg_shift;
                    relu_d    = cfg_relu;
                    k_d       = '0;
                    n_d       = '0;
                    w_d       = '0;
                end
            end
            ST_RUN: begin
                issue_vld   = 1'b1;
                issue_first = (k_q == '0);
                issue_last  = (k_q == words_q - 16'd1);
                issue_fin   = issue_last && (n_q == neurons_q - 16'd1);
                w_d         = w_q + AW'(1);
                if (issue_last) begin
                    k_d = '0;
                    n_d = n_q + 16'd1;
                end else begin
                    k_d = k_q + 16'd1;
                end
                if (issue_fin) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (fin_wr_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: stage 1 = rdata, stage 2 = sum_q into acc, stage 3 = acc into pack.
    always_comb begin
        vld_pipe_d   = {vld_pipe_q[2:1], issue_vld};
        first_pipe_d = {first_pipe_q[1], issue_first};
        last_pipe_d  = {last_pipe_q[2:1], issue_last};
        fin_pipe_d   = {fin_pipe_q[2:1], issue_fin};

        acc_d = acc_q;
        if (vld_pipe_q[2]) acc_d = first_pipe_q[2] ? sum_q : acc_q + sum_q;

        sh = acc_q >>> shift_q;
        if (relu_q && sh[ACC_W-1]) sh = '0;
        if (sh > RES_MAX)      res = {1'b0, {(DW-1){1'b1}}};
        else if (sh < RES_MIN) res = {1'b1, {(DW-1){1'b0}}};
        else                   res = sh[DW-1:0];

        // A pack being written this cycle is retired, so the next result lands in a clean pack.
        wr       = vld_pipe_q[3] && last_pipe_q[3];
        pack_d   = out_we_q ? '0 : pack_q;
        slot_d   = slot_q;
        out_we_d = 1'b0;
        fin_wr_d = 1'b0;
        if (wr) begin
            pack_d[SW'(LANES-1) - slot_q] = res;
            out_we_d = (slot_q == SW'(LANES-1)) || fin_pipe_q[3];
            fin_wr_d = fin_pipe_q[3];
            slot_d   = (slot_q == SW'(LANES-1)) ? '0 : slot_q + SW'(1);
        end

        out_addr_d = out_we_q ? out_addr_q + AW'(1) : out_addr_q;
        if (launch_d) begin
            out_addr_d = '0;
            slot_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            launch_q     <= 1'b0;
            words_q      <= '0;
            neurons_q    <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            k_q          <= '0;
            n_q          <= '0;
            w_q          <= '0;
            vld_pipe_q   <= '0;
            first_pipe_q <= '0;
            last_pipe_q  <= '0;
            fin_pipe_q   <= '0;
            acc_q        <= '0;
            slot_q       <= '0;
            pack_q       <= '0;
            out_we_q     <= 1'b0;
            fin_wr_q     <= 1'b0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            launch_q     <= launch_d;
            words_q      <= words_d;
            neurons_q    <= neurons_d;
            shift_q      <= shift_d;
            relu_q       <= relu_d;
            k_q          <= k_d;
            n_q          <= n_d;
            w_q          <= w_d;
            vld_pipe_q   <= vld_pipe_d;
            first_pipe_q <= first_pipe_d;
            last_pipe_q  <= last_pipe_d;
            fin_pipe_q   <= fin_pipe_d;
            acc_q        <= acc_d;
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            out_we_q     <= out_we_d;
            fin_wr_q     <= fin_wr_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign busy      = launch_q || (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign ifm_en    = (state_q == ST_RUN);
    assign w_en      = ifm_en;
    assign ifm_addr  = ifm_en ? AW'(k_q) : '0;
    assign w_addr    = ifm_en ? w_q : '0;
    assign out_we    = out_we_q;
    assign out_addr  = out_addr_q;
    assign out_wdata = out_we_q ? pack_q : '0;

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: expected writes are queued at launch and
// matched against out_we beats; latency and reset behaviour checked alongside.
module tb_conv_engine;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int W     = LANES * DW;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0]   cfg_n_words = '0, cfg_n_neurons = '0;
    logic [4:0]    cfg_shift = '0;
    logic          cfg_relu = 1'b0;
    logic          busy, done, ifm_en, w_en, out_we;
    logic [AW-1:0] ifm_addr, w_addr, out_addr;
    logic [W-1:0]  ifm_rdata = '0, w_rdata = '0, out_wdata;

    logic [W-1:0]  ifm_mem [64];
    logic [W-1:0]  w_mem   [64];

    typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
    wr_t sb_q [$];
    wr_t mon_e;

    int errs = 0, checks = 0;
    int cyc = 0, en_seen = 0, we_seen = 0, last_we_cyc = 0, done_gap = 0;
    logic [AW-1:0] wmax = '0;

    conv_engine #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_n_words   (cfg_n_words),
        .cfg_n_neurons (cfg_n_neurons),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .busy          (busy),
        .done          (done),
        .ifm_en        (ifm_en),
        .ifm_addr      (ifm_addr),
        .ifm_rdata     (ifm_rdata),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_rdata       (w_rdata),
        .out_we        (out_we),
        .out_addr      (out_addr),
        .out_wdata     (out_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifm_en) ifm_rdata <= ifm_mem[ifm_addr[5:0]];
        if (w_en)   w_rdata   <= w_mem[w_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (ifm_en) begin
                en_seen++;
                if (w_addr > wmax) wmax = w_addr;
            end
            if (out_we) begin
                we_seen++;
                last_we_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_addr", out_addr, mon_e.addr);
                    chk("out_wdata", out_wdata, mon_e.data);
                end
            end
            if (done) done_gap = cyc - last_we_cyc;
        end
    end

    function automatic logic [W-1:0] rep(input int v);
        logic [DW-1:0] x;
        x = v[DW-1:0];
        return {LANES{x}};
    endfunction

    function automatic logic [W-1:0] lane0(input int v);
        logic [W-1:0] r;
        r = '0;
        r[W-1 -: DW] = v[DW-1:0];
        return r;
    endfunction

    task automatic fill(input logic [W-1:0] iv, input logic [W-1:0] wv);
        for (int i = 0; i < 64; i++) begin
            ifm_mem[i] = iv;
            w_mem[i]   = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            for (int l = 0; l < LANES; l++) begin
                ifm_mem[i][l*DW +: DW] = DW'(int'($urandom_range(400)) - 200);
                w_mem[i][l*DW +: DW]   = DW'(int'($urandom_range(400)) - 200);
            end
        end
    endtask

    task automatic push_model(input int words, input int neurons, input int sh, input bit relu);
        longint acc, r;
        logic [W-1:0] pack;
        logic [DW-1:0] a, b;
        int slot, addr;
        pack = '0; slot = 0; addr = 0;
        for (int n = 0; n < neurons; n++) begin
            acc = 0;
            for (int k = 0; k < words; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    a = ifm_mem[k][(LANES-1-l)*DW +: DW];
                    b = w_mem[n*words+k][(LANES-1-l)*DW +: DW];
                    acc += longint'($signed(a)) * longint'($signed(b));
                end
            end
            r = acc >>> sh;
            if (relu && r < 0) r = 0;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            pack[(LANES-1-slot)*DW +: DW] = r[DW-1:0];
            slot++;
            if (slot == LANES || n == neurons - 1) begin
                sb_q.push_back('{AW'(addr), pack});
                addr++; slot = 0; pack = '0;
            end
        end
    endtask

    task automatic launch(input int words, input int neurons, input int sh, input bit relu);
        @(negedge clk);
        cfg_n_words = 16'(words); cfg_n_neurons = 16'(neurons);
        cfg_shift = 5'(sh); cfg_relu = relu; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scrambled cfg after the pulse must not reach the layer.
        cfg_n_words = 16'hFFFF; cfg_n_neurons = 16'hFFFF; cfg_shift = 5'h1F; cfg_relu = ~relu;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        #1;
    endtask

    task automatic finish_layer(input bit has_wr);
        int n;
        wait_done(n);
        if (has_wr) chk("done_after_last_we", 64'(done_gap), 64'd1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run(input int words, input int neurons, input int sh, input bit relu);
        launch(words, neurons, sh, relu);
        finish_layer(1'b1);
    endtask

    initial begin
        int n, k, en0, we0;
        fill('0, '0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_ifm_en", ifm_en, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_out_wdata", out_wdata, 0);
        rst_n = 1'b1;

        // All ones, one word per neuron: four results of 4 in one pack.
        fill(rep(1), rep(1));
        sb_q.push_back('{16'd0, 64'h0004_0004_0004_0004});
        run(1, 4, 0, 0);

        // 3 words x 4 lanes x 2*3 = 72; fifth neuron spills to a second, partial pack.
        fill(rep(2), rep(3));
        sb_q.push_back('{16'd0, rep(72)});
        sb_q.push_back('{16'd1, lane0(72)});
        wmax = '0;
        run(3, 5, 0, 0);
        chk("w_addr_max", wmax, 14);

        // -100*100 = -10000: ReLU clamps to 0; without ReLU, >>>2 gives -2500.
        fill(lane0(-100), rep(100));
        sb_q.push_back('{16'd0, 64'h0});
        run(1, 1, 0, 1);
        sb_q.push_back('{16'd0, {16'hF63C, 48'h0}});
        run(1, 1, 2, 0);

        // +/-40000 saturate to the signed 16-bit limits.
        fill(lane0(200), rep(200));
        sb_q.push_back('{16'd0, {16'h7FFF, 48'h0}});
        run(1, 1, 0, 0);
        fill(lane0(-200), rep(200));
        sb_q.push_back('{16'd0, {16'h8000, 48'h0}});
        run(1, 1, 0, 0);

        for (int it = 0; it < 3; it++) begin
            int rw, rn, rs;
            bit rr;
            rw = int'($urandom_range(2, 4));
            rn = int'($urandom_range(5, 9));
            rs = int'($urandom_range(0, 6));
            rr = it[0];
            fill_rand();
            push_model(rw, rn, rs, rr);
            run(rw, rn, rs, rr);
        end

        // A second start while running is ignored.
        fill(rep(2), rep(3));
        sb_q.push_back('{16'd0, rep(72)});
        sb_q.push_back('{16'd1, lane0(72)});
        launch(3, 5, 0, 0);
        repeat (3) @(negedge clk);
        cfg_n_words = 16'd1; cfg_n_neurons = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_layer(1'b1);

        // Reset mid-layer while a write is on the bus.
        fill(rep(1), rep(1));
        push_model(1, 12, 0, 0);
        launch(1, 12, 0, 0);
        k = 0;
        while (!out_we && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        chk("we_before_reset", out_we, 1);
        chk("run_before_reset", ifm_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_we", out_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ifm_en", ifm_en, 0);
        chk("midrst_out_wdata", out_wdata, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we0 = we_seen;
        repeat (10) @(negedge clk);
        chk("no_we_after_reset", 64'(we_seen - we0), 64'd0);
        chk("idle_after_reset", busy, 0);
        sb_q.push_back('{16'd0, 64'h0004_0004_0004_0004});
        run(1, 4, 0, 0);

        // Empty layers: done two cycles after start, no memory traffic.
        en0 = en_seen; we0 = we_seen;
        launch(0, 4, 0, 0);
        wait_done(n);
        chk("zero_words_done_lat", 64'(n), 64'd2);
        @(negedge clk);
        chk("zero_words_done_one", done, 0);
        launch(3, 0, 0, 0);
        wait_done(n);
        chk("zero_neurons_done_lat", 64'(n), 64'd2);
        @(negedge clk);
        chk("zero_en", 64'(en_seen - en0), 64'd0);
        chk("zero_we", 64'(we_seen - we0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
